// File: rtl/sobel_pkg.sv
// Shared types and helpers for the sobel frame controller.
package sobel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FEED,
    ST_DRAIN,
    ST_DONE
  } state_t;

  function automatic int unsigned frame_pixels(input int unsigned width,
                                               input int unsigned height);
    return width * height;
  endfunction

endpackage

// File: rtl/sobel_beat_counter.sv
// Modulo-COUNT_P beat counter; wrap_o flags the increment that returns it to zero.
module sobel_beat_counter #(
  parameter int unsigned COUNT_P = 8,
  parameter int unsigned CNT_W   = (COUNT_P > 1) ? $clog2(COUNT_P) : 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o,
  output logic             wrap_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT_P - 1);

  assign wrap_o = inc_i && (count_o == LAST);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_o <= '0;
    end else if (clear_i) begin
      count_o <= '0;
    end else if (inc_i) begin
      if (wrap_o) count_o <= '0;
      else        count_o <= count_o + 1'b1;
    end
  end

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame-level run controller: gates an upstream pixel stream into the sobel
// pipeline for a set number of frames and tracks frames leaving the pipeline.
module sobel_frame_ctrl
  import sobel_pkg::*;
#(
  parameter int unsigned WIDTH_P  = 640,
  parameter int unsigned HEIGHT_P = 480
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [7:0]  frames_i,
  input  logic        abort_i,
  input  logic        src_valid_i,
  output logic        src_ready_o,
  input  logic [31:0] src_pixel_i,
  output logic        pipe_valid_o,
  input  logic        pipe_ready_i,
  output logic [31:0] pipe_pixel_o,
  input  logic        out_valid_i,
  input  logic        out_ready_i,
  input  logic        out_last_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        aborted_o,
  output logic [7:0]  frame_cnt_o,
  output logic        err_o
);

  localparam int unsigned PIX_N = frame_pixels(WIDTH_P, HEIGHT_P);
  localparam int unsigned PIX_W = (PIX_N > 1) ? $clog2(PIX_N) : 1;

  state_t           state, state_nxt;
  logic [7:0]       target;
  logic [7:0]       fed_cnt;
  logic [7:0]       done_cnt;
  logic             abort_flag;
  logic             err;
  logic [PIX_W-1:0] pix_cnt;
  logic             frame_end;
  logic             in_feed;
  logic             beat;
  logic             start_ok;
  logic             out_evt;
  logic             abort_any;

  assign in_feed      = (state == ST_FEED);
  assign busy_o       = in_feed || (state == ST_DRAIN);
  assign pipe_valid_o = in_feed & src_valid_i;
  assign src_ready_o  = in_feed & pipe_ready_i;
  assign pipe_pixel_o = src_pixel_i;
  assign beat         = pipe_valid_o & pipe_ready_i;
  assign start_ok     = (state == ST_IDLE) && start_i && (frames_i != 8'd0);
  assign out_evt      = busy_o && out_valid_i && out_ready_i && out_last_i;
  assign abort_any    = abort_i | abort_flag;
  assign done_o       = (state == ST_DONE);
  assign aborted_o    = done_o & abort_flag;
  assign frame_cnt_o  = done_cnt;
  assign err_o        = err;

  sobel_beat_counter #(
    .COUNT_P (PIX_N),
    .CNT_W   (PIX_W)
  ) u_pix_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (start_ok),
    .inc_i   (beat),
    .count_o (pix_cnt),
    .wrap_o  (frame_end)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_ok) state_nxt = ST_FEED;
      ST_FEED: begin
        // Abort only takes effect on a frame boundary: either idle at pixel 0
        // or on the beat that completes the current frame.
        if (frame_end && (fed_cnt + 8'd1 == target))
          state_nxt = ST_DRAIN;
        else if (abort_any && (((pix_cnt == '0) && !beat) || frame_end))
          state_nxt = ST_DRAIN;
      end
      ST_DRAIN: if (done_cnt == fed_cnt) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state      <= ST_IDLE;
      target     <= '0;
      fed_cnt    <= '0;
      done_cnt   <= '0;
      abort_flag <= 1'b0;
      err        <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        target   <= frames_i;
        fed_cnt  <= '0;
        done_cnt <= '0;
        err      <= 1'b0;
      end else begin
        if (frame_end) fed_cnt <= fed_cnt + 8'd1;
        if (out_evt) begin
          if (done_cnt < fed_cnt) done_cnt <= done_cnt + 8'd1;
          else                    err      <= 1'b1;
        end
      end
      if (busy_o && abort_i)    abort_flag <= 1'b1;
      else if (state == ST_DONE) abort_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Directed bench for sobel_frame_ctrl with a 4x2 frame.
module tb_sobel_frame_ctrl;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic [7:0]  frames_i;
  logic        abort_i;
  logic        src_valid_i;
  logic        src_ready_o;
  logic [31:0] src_pixel_i;
  logic        pipe_valid_o;
  logic        pipe_ready_i;
  logic [31:0] pipe_pixel_o;
  logic        out_valid_i;
  logic        out_ready_i;
  logic        out_last_i;
  logic        busy_o;
  logic        done_o;
  logic        aborted_o;
  logic [7:0]  frame_cnt_o;
  logic        err_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  sobel_frame_ctrl #(
    .WIDTH_P  (4),
    .HEIGHT_P (2)
  ) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .start_i      (start_i),
    .frames_i     (frames_i),
    .abort_i      (abort_i),
    .src_valid_i  (src_valid_i),
    .src_ready_o  (src_ready_o),
    .src_pixel_i  (src_pixel_i),
    .pipe_valid_o (pipe_valid_o),
    .pipe_ready_i (pipe_ready_i),
    .pipe_pixel_o (pipe_pixel_o),
    .out_valid_i  (out_valid_i),
    .out_ready_i  (out_ready_i),
    .out_last_i   (out_last_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .aborted_o    (aborted_o),
    .frame_cnt_o  (frame_cnt_o),
    .err_o        (err_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_run(input logic [7:0] f);
    start_i  = 1'b1;
    frames_i = f;
    tick();
    start_i  = 1'b0;
    frames_i = 8'd0;
  endtask

  // Continuous source until the controller stops accepting; optional abort on a beat.
  task automatic feed(input int abort_beat, output int acc);
    acc          = 0;
    src_valid_i  = 1'b1;
    pipe_ready_i = 1'b1;
    for (int n = 0; n < 60; n++) begin
      src_pixel_i = $urandom;
      #1;
      if (!src_ready_o) break;
      acc++;
      check("feed_pixel", pipe_pixel_o, src_pixel_i);
      if (acc == abort_beat) abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
    end
    src_valid_i = 1'b0;
  endtask

  task automatic out_frame();
    for (int b = 0; b < 8; b++) begin
      out_valid_i = 1'b1;
      out_ready_i = 1'b1;
      out_last_i  = (b == 7);
      tick();
    end
    out_valid_i = 1'b0;
    out_ready_i = 1'b0;
    out_last_i  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input logic exp_abort, input logic [7:0] exp_frames);
    int n = 0;
    while (!done_o && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_done"}, done_o, 1);
    check({tag, "_aborted"}, aborted_o, exp_abort);
    check({tag, "_frames"}, frame_cnt_o, exp_frames);
    tick();
    check({tag, "_done_pulse"}, done_o, 0);
    check({tag, "_idle"}, busy_o, 0);
    check({tag, "_held"}, frame_cnt_o, exp_frames);
  endtask

  initial begin
    int acc;
    int n;
    reset_i      = 1'b1;
    start_i      = 1'b0;
    frames_i     = 8'd0;
    abort_i      = 1'b0;
    src_valid_i  = 1'b1;
    src_pixel_i  = 32'h0;
    pipe_ready_i = 1'b1;
    out_valid_i  = 1'b0;
    out_ready_i  = 1'b0;
    out_last_i   = 1'b0;
    tick();
    tick();
    check("rst_busy", busy_o, 0);
    check("rst_src_ready", src_ready_o, 0);
    check("rst_pipe_valid", pipe_valid_o, 0);
    check("rst_frames", frame_cnt_o, 0);
    check("rst_err", err_o, 0);
    check("rst_done", done_o, 0);
    reset_i = 1'b0;
    tick();
    check("idle_src_ready", src_ready_o, 0);

    // frames_i = 0 must not start a run
    start_run(8'd0);
    check("zero_start_busy", busy_o, 0);

    // Two full frames
    start_run(8'd2);
    check("run2_busy", busy_o, 1);
    feed(0, acc);
    check("run2_beats", acc, 16);
    check("run2_drain_busy", busy_o, 1);
    check("run2_pipe_valid_off", pipe_valid_o, 0);
    check("run2_no_early_done", done_o, 0);
    out_frame();
    out_frame();
    wait_done("run2", 1'b0, 8'd2);
    tick();
    check("run2_single_done", done_o, 0);

    // Abort on beat 3 of the first frame: rest of that frame is still fed
    start_run(8'd3);
    feed(3, acc);
    check("abort_mid_beats", acc, 8);
    out_frame();
    wait_done("abort_mid", 1'b1, 8'd1);

    // Abort exactly at a frame boundary with no beat that cycle
    start_run(8'd3);
    for (int i = 0; i < 8; i++) begin
      src_valid_i = 1'b1;
      src_pixel_i = 32'(i);
      tick();
    end
    src_valid_i = 1'b0;
    abort_i     = 1'b1;
    tick();
    abort_i     = 1'b0;
    src_valid_i = 1'b1;
    #1;
    check("abort_edge_src_ready", src_ready_o, 0);
    check("abort_edge_busy", busy_o, 1);
    src_valid_i = 1'b0;
    out_frame();
    wait_done("abort_edge", 1'b1, 8'd1);

    // Abort before anything is fed: empty run
    start_run(8'd5);
    src_valid_i = 1'b0;
    abort_i     = 1'b1;
    tick();
    abort_i = 1'b0;
    check("abort_imm_src_ready", src_ready_o, 0);
    wait_done("abort_imm", 1'b1, 8'd0);

    // Spurious output last while nothing is outstanding
    start_run(8'd1);
    out_valid_i = 1'b1;
    out_ready_i = 1'b1;
    out_last_i  = 1'b1;
    tick();
    out_valid_i = 1'b0;
    out_ready_i = 1'b0;
    out_last_i  = 1'b0;
    check("err_set", err_o, 1);
    check("err_frames", frame_cnt_o, 0);
    feed(0, acc);
    check("err_run_beats", acc, 8);
    out_frame();
    wait_done("err_run", 1'b0, 8'd1);
    check("err_sticky", err_o, 1);

    // Random backpressure on both sides
    start_run(8'd2);
    check("err_cleared", err_o, 0);
    acc = 0;
    n   = 0;
    while (acc < 16 && n < 400) begin
      src_valid_i  = 1'($urandom_range(0, 1));
      pipe_ready_i = 1'($urandom_range(0, 1));
      src_pixel_i  = $urandom;
      #1;
      check("bp_valid", pipe_valid_o, src_valid_i);
      check("bp_ready", src_ready_o, pipe_ready_i);
      if (src_valid_i && src_ready_o) begin
        acc++;
        check("bp_pixel", pipe_pixel_o, src_pixel_i);
      end
      tick();
      n++;
    end
    check("bp_beats", acc, 16);
    src_valid_i  = 1'b1;
    pipe_ready_i = 1'b1;
    #1;
    check("bp_stop_ready", src_ready_o, 0);
    check("bp_stop_valid", pipe_valid_o, 0);
    src_valid_i = 1'b0;
    out_frame();
    out_frame();
    wait_done("bp", 1'b0, 8'd2);

    // Asynchronous reset in the middle of a feed
    start_run(8'd2);
    src_valid_i = 1'b1;
    tick();
    tick();
    tick();
    #2;
    check("prereset_busy", busy_o, 1);
    reset_i = 1'b1;
    #1;
    check("areset_busy", busy_o, 0);
    check("areset_src_ready", src_ready_o, 0);
    check("areset_pipe_valid", pipe_valid_o, 0);
    check("areset_frames", frame_cnt_o, 0);
    #2;
    reset_i     = 1'b0;
    src_valid_i = 1'b0;
    tick();
    start_run(8'd1);
    feed(0, acc);
    check("post_reset_beats", acc, 8);
    out_frame();
    wait_done("post_reset", 1'b0, 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sobel_frame_ctrl.md
SOBEL_FRAME_CTRL -- requirements
Module: sobel_frame_ctrl

Interface
REQ-001 SHALL have parameter WIDTH_P, default 640, frame width in pixels.
REQ-002 SHALL have parameter HEIGHT_P, default 480, frame height in pixels.
REQ-003 SHALL have one clock and one reset: reset is asynchronous and active-high.
REQ-004 clk_i  input  1  sole clock; all state on rising edge.
REQ-005 reset_i  input  1  asynchronous active-high reset.
REQ-006 start_i  input  1  begin a run; sampled only in IDLE.
REQ-007 frames_i  input  8  number of frames to run; latched on accepted start.
REQ-008 abort_i  input  1  stop the run at the next input frame boundary.
REQ-009 src_valid_i / src_ready_o / src_pixel_i  in/out/in  1/1/32  upstream pixel stream.
REQ-010 pipe_valid_o / pipe_ready_i / pipe_pixel_o  out/in/out  1/1/32  stream into the sobel pipeline.
REQ-011 out_valid_i / out_ready_i / out_last_i  in/in/in  1/1/1  monitored pipeline output handshake and last flag.
REQ-012 busy_o  output  1  high in FEED or DRAIN.
REQ-013 done_o  output  1  one-cycle pulse when a run ends.
REQ-014 aborted_o  output  1  valid with done_o; 1 if the run ended by abort.
REQ-015 frame_cnt_o  output  8  frames completed at pipeline output in the current or last run.
REQ-016 err_o  output  1  sticky: output last seen with no frame outstanding.

Function
REQ-017 FSM states SHALL be IDLE, FEED, DRAIN, DONE.
REQ-018 IDLE->FEED on start_i=1 with frames_i!=0; this latches target, clears pix_cnt, fed_cnt, done_cnt and err_o; start_i with frames_i=0 is ignored.
REQ-019 In FEED: pipe_valid_o=src_valid_i, src_ready_o=pipe_ready_i, pipe_pixel_o=src_pixel_i, all combinational (zero latency, no buffering).
REQ-020 Outside FEED: pipe_valid_o=0 and src_ready_o=0; pipe_pixel_o still mirrors src_pixel_i.
REQ-021 Input beat (pipe_valid_o & pipe_ready_i) SHALL increment pix_cnt; at WIDTH_P*HEIGHT_P-1 it wraps to 0 and fed_cnt increments.
REQ-022 FEED->DRAIN in the same cycle fed_cnt reaches target; src_ready_o is low from the next cycle.
REQ-023 abort_i pulse in FEED or DRAIN SHALL latch an abort flag.
REQ-024 Abort in FEED: if pix_cnt=0 and no beat that cycle, go to DRAIN next cycle; otherwise go to DRAIN when the current frame's last beat is accepted.
REQ-025 Output frame event = out_valid_i & out_ready_i & out_last_i; it increments done_cnt when done_cnt<fed_cnt, otherwise sets err_o and leaves done_cnt unchanged.
REQ-026 Output events SHALL be counted in FEED and DRAIN, including the same cycle as a FEED->DRAIN transition.
REQ-027 DRAIN->DONE when done_cnt==fed_cnt, including fed_cnt=0 after an immediate abort.
REQ-028 DONE SHALL last one cycle, assert done_o and aborted_o=abort flag, then return to IDLE and clear the abort flag.
REQ-029 frame_cnt_o=done_cnt, held through IDLE until the next accepted start.
REQ-030 Counters SHALL be sized $clog2(WIDTH_P*HEIGHT_P) for pix_cnt and 8 bits for fed_cnt/done_cnt; they never exceed target.
REQ-031 abort_i in IDLE or DONE SHALL be ignored; start_i outside IDLE SHALL be ignored.

Reset
REQ-032 reset_i SHALL put the FSM in IDLE and clear all counters, the abort flag, done_o, aborted_o and err_o immediately, independent of clk_i.
REQ-033 Reset mid-run drops the in-flight frame count; src_ready_o and pipe_valid_o are 0 while reset_i=1.

Structure
REQ-034 Package sobel_pkg SHALL hold the state enum type and a function returning WIDTH_P*HEIGHT_P pixel count.
REQ-035 Sub-module sobel_beat_counter SHALL implement the wrap counter with inc, clear and wrap outputs; it is used for pix_cnt.

Verification (WIDTH_P=4, HEIGHT_P=2 unless stated)
REQ-036 frames_i=2, continuous source, out_last every 8th output beat -> 16 input beats pass, src_ready_o low after beat 16, done_o once, frame_cnt_o=2, aborted_o=0.
REQ-037 frames_i=3, abort_i at input beat 3 of frame 1 -> beats through 8 accepted, then none; done_o after 1 output last, frame_cnt_o=1, aborted_o=1.
REQ-038 Abort asserted at a frame boundary, no beat that cycle -> DRAIN next cycle, no extra frame fed.
REQ-039 out_last_i with out_valid_i&out_ready_i while done_cnt==fed_cnt -> err_o=1, frame_cnt_o unchanged, err_o cleared on next start.
REQ-040 Random pipe_ready_i/src_valid_i backpressure -> no beat lost or duplicated; pipe_pixel_o equals src_pixel_i on every accepted beat.
REQ-041 reset_i asserted mid-FEED between clock edges -> busy_o, src_ready_o and pipe_valid_o go to 0 without a clock edge; start_i afterwards runs normally.
